game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000: clk cycles per game tick; legal range 2..2^20.
REQ-002 Parameter PAUSE_TICKS, default 32: game ticks spent in PAUSE; legal range 1..255.
REQ-003 Parameter LIVES, default 3: lives loaded at game start; legal range 1..3.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 startPulse  in  1  one-cycle start request from the player block.
REQ-007 hit  in  1  one-cycle pulse: player bullet destroyed an invader.
REQ-008 shipHit  in  1  one-cycle pulse: invader bullet struck the ship.
REQ-009 allDead  in  1  level: every invader destroyed.
REQ-010 landed  in  1  level: invaders reached the ship row.
REQ-011 clear  out  1  clears player/invader/bullet datapath.
REQ-012 ScoreClear  out  1  clears the player score.
REQ-013 Enable  out  1  one-cycle game-tick strobe to player and invaders.
REQ-014 lives  out  2  remaining lives.
REQ-015 level  out  3  current level, 0-based.
REQ-016 state  out  3  FSM state code.
REQ-017 gameOver  out  1  high while in OVER.

Function
REQ-018 States and codes: IDLE=0, INIT=1, PLAY=2, PAUSE=3, RESUME=4, OVER=5; codes 6-7 go to IDLE next cycle.
REQ-019 IDLE: startPulse -> INIT; all other inputs ignored.
REQ-020 INIT: lasts exactly one cycle; clear=1, ScoreClear=1; lives<=LIVES, level<=0, hit counter<=0, prescaler<=0; next PLAY.
REQ-021 PLAY priority, highest first: landed -> OVER with lives<=0; shipHit with lives<=1 -> OVER with lives<=0; shipHit with lives>1 -> PAUSE with lives<=lives-1; allDead -> PAUSE with level<=min(level+1,7); otherwise remain.
REQ-022 PAUSE: counts PAUSE_TICKS prescaler wraps, then RESUME; Enable held 0; pause counter zeroed on entry.
REQ-023 RESUME: lasts exactly one cycle; clear=1, ScoreClear=0; lives and level unchanged; next PLAY.
REQ-024 OVER: gameOver=1; startPulse -> INIT; all other inputs ignored.
REQ-025 Prescaler: counts 0..TICK_DIV-1 and wraps in PLAY and PAUSE; held at 0 in all other states.
REQ-026 Enable=1 only in the PLAY cycle where the prescaler equals TICK_DIV-1, including a cycle that leaves PLAY.
REQ-027 clear, ScoreClear, Enable, gameOver: Moore outputs decoded from registered state/prescaler; no combinational path from inputs.
REQ-028 Bonus life: 4-bit hit counter increments on hit in PLAY only. On wrap 15->0, lives<=min(lives+1,3). A same-cycle shipHit takes precedence; the bonus is then dropped.
REQ-029 level saturates at 7; further allDead events still enter PAUSE.
REQ-030 startPulse in PLAY, PAUSE, INIT or RESUME is ignored.

Reset
REQ-031 While reset=0: state=IDLE; lives=0, level=0, prescaler=0, pause counter=0, hit counter=0.
REQ-032 While reset=0: clear=0, ScoreClear=0, Enable=0, gameOver=0.
REQ-033 Reset deassertion mid-game always resumes in IDLE; no state is retained.

Verification (TICK_DIV=4, PAUSE_TICKS=2, LIVES=3)
REQ-034 Reset, then startPulse -> one cycle INIT with clear=ScoreClear=1, lives=3, level=0; then PLAY with Enable every 4th cycle.
REQ-035 In PLAY, shipHit three times, each after PAUSE/RESUME completes:
  - after each of the first two, PAUSE lasts 8 cycles and lives=2 then 1;
  - after each of the first two, RESUME pulses clear with ScoreClear=0;
  - the third shipHit -> OVER, lives=0, gameOver=1.
REQ-036 In PLAY, assert landed and shipHit in the same cycle -> OVER, lives=0, no PAUSE.
REQ-037 allDead eight times -> level 1..7, then stays 7.
REQ-038 Hit pulses in PLAY:
  - 16 hits with lives=2 -> lives=3;
  - 16 more hits -> lives stays 3;
  - 16th hit coincident with shipHit -> lives decrements only.
REQ-039 Assert reset during PAUSE -> all outputs 0 asynchronously; after release state=IDLE; startPulse restarts at INIT.

Source files
------------

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencing FSM: start/pause/resume/game-over, lives, level and tick strobe
module game_ctrl #(
    parameter int TICK_DIV    = 25000,
    parameter int PAUSE_TICKS = 32,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startPulse,
    input  logic       hit,
    input  logic       shipHit,
    input  logic       allDead,
    input  logic       landed,
    output logic       clear,
    output logic       ScoreClear,
    output logic       Enable,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [2:0] state,
    output logic       gameOver
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX      = PW'(TICK_DIV - 1);
    localparam logic [7:0]    PAUSE_LAST = 8'(PAUSE_TICKS - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSE  = 3'd3,
        S_RESUME = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_lives;
    logic [2:0]      r_level;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_pause;
    logic [3:0]      r_hits;

    logic            w_wrap;
    logic [PW-1:0]   w_presc_next;
    logic            w_bonus;

    assign w_wrap       = (r_presc == P_MAX);
    assign w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
    assign w_bonus      = hit && (r_hits == 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_lives <= 2'd0;
            r_level <= 3'd0;
            r_presc <= '0;
            r_pause <= 8'd0;
            r_hits  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    // New game values are loaded on entry so they are visible during INIT.
                    if (startPulse) begin
                        r_state <= S_INIT;
                        r_lives <= LIVES_INIT;
                        r_level <= 3'd0;
                        r_hits  <= 4'd0;
                        r_presc <= '0;
                        r_pause <= 8'd0;
                    end
                end
                S_INIT: begin
                    r_state <= S_PLAY;
                    r_lives <= LIVES_INIT;
                    r_level <= 3'd0;
                    r_hits  <= 4'd0;
                    r_presc <= '0;
                    r_pause <= 8'd0;
                end
                S_PLAY: begin
                    r_presc <= w_presc_next;
                    if (hit) begin
                        r_hits <= r_hits + 4'd1;
                    end
                    if (landed) begin
                        r_state <= S_OVER;
                        r_lives <= 2'd0;
                        r_presc <= '0;
                    end else if (shipHit) begin
                        if (r_lives <= 2'd1) begin
                            r_state <= S_OVER;
                            r_lives <= 2'd0;
                            r_presc <= '0;
                        end else begin
                            r_state <= S_PAUSE;
                            r_lives <= r_lives - 2'd1;
                            r_presc <= '0;
                            r_pause <= 8'd0;
                        end
                    end else begin
                        if (w_bonus && (r_lives != 2'd3)) begin
                            r_lives <= r_lives + 2'd1;
                        end
                        if (allDead) begin
                            r_state <= S_PAUSE;
                            r_presc <= '0;
                            r_pause <= 8'd0;
                            if (r_level != 3'd7) begin
                                r_level <= r_level + 3'd1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    // Prescaler restarts on entry, so the pause is exactly PAUSE_TICKS*TICK_DIV cycles.
                    r_presc <= w_presc_next;
                    if (w_wrap) begin
                        if (r_pause == PAUSE_LAST) begin
                            r_state <= S_RESUME;
                            r_pause <= 8'd0;
                        end else begin
                            r_pause <= r_pause + 8'd1;
                        end
                    end
                end
                S_RESUME: begin
                    r_state <= S_PLAY;
                    r_presc <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_presc <= '0;
                    r_pause <= 8'd0;
                end
            endcase
        end
    end

    assign clear      = (r_state == S_INIT) || (r_state == S_RESUME);
    assign ScoreClear = (r_state == S_INIT);
    assign Enable     = (r_state == S_PLAY) && w_wrap;
    assign gameOver   = (r_state == S_OVER);
    assign lives      = r_lives;
    assign level      = r_level;
    assign state      = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed vector bench for game_ctrl (TICK_DIV=4, PAUSE_TICKS=2, LIVES=3)
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       startPulse, hit, shipHit, allDead, landed;
    logic       clear, ScoreClear, Enable, gameOver;
    logic [1:0] lives;
    logic [2:0] level, state;

    int n_tests = 0;
    int n_fail  = 0;

    game_ctrl #(.TICK_DIV(4), .PAUSE_TICKS(2), .LIVES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .startPulse (startPulse),
        .hit        (hit),
        .shipHit    (shipHit),
        .allDead    (allDead),
        .landed     (landed),
        .clear      (clear),
        .ScoreClear (ScoreClear),
        .Enable     (Enable),
        .lives      (lives),
        .level      (level),
        .state      (state),
        .gameOver   (gameOver)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, hi, sh, ad, ld;
        logic [2:0] e_state;
        logic [1:0] e_lives;
        logic [2:0] e_level;
        logic       e_clr, e_sc, e_en, e_go;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic hi, input logic sh, input logic ad, input logic ld);
        startPulse = st; hit = hi; shipHit = sh; allDead = ad; landed = ld;
        @(posedge clk);
        #1;
        startPulse = 0; hit = 0; shipHit = 0; allDead = 0; landed = 0;
    endtask

    task automatic wait_play(input string name);
        int n = 0;
        while (state != 3'd2 && n < 40) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk(name, int'(state), 2);
    endtask

    task automatic wait_pause_out(output int cnt);
        cnt = 1;
        while (state == 3'd3 && cnt < 40) begin
            cyc(0, 0, 0, 0, 0);
            if (state == 3'd3) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic [11:0] got, exp;

        vecs[0]  = '{1,0,0,0,0, 3'd1, 2'd3, 3'd0, 1,1,0,0};
        vecs[1]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[2]  = '{1,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[3]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[4]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,1,0};
        vecs[5]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[6]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[7]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,0,0};
        vecs[8]  = '{0,0,0,0,0, 3'd2, 2'd3, 3'd0, 0,0,1,0};
        vecs[9]  = '{0,0,1,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[10] = '{0,0,0,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[11] = '{1,0,0,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[12] = '{0,0,0,1,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[13] = '{0,0,1,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[14] = '{0,0,0,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[15] = '{0,0,0,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[16] = '{0,0,0,0,0, 3'd3, 2'd2, 3'd0, 0,0,0,0};
        vecs[17] = '{0,0,0,0,0, 3'd4, 2'd2, 3'd0, 1,0,0,0};
        vecs[18] = '{0,0,0,0,0, 3'd2, 2'd2, 3'd0, 0,0,0,0};

        reset = 0; startPulse = 0; hit = 0; shipHit = 0; allDead = 0; landed = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({lives, level, clear, ScoreClear, Enable, gameOver}), 0);
        reset = 1;

        cyc(0, 0, 0, 0, 0);
        chk("idle_hold", int'(state), 0);

        for (int i = 0; i < 19; i++) begin
            cyc(vecs[i].st, vecs[i].hi, vecs[i].sh, vecs[i].ad, vecs[i].ld);
            got = {state, lives, level, clear, ScoreClear, Enable, gameOver};
            exp = {vecs[i].e_state, vecs[i].e_lives, vecs[i].e_level,
                   vecs[i].e_clr, vecs[i].e_sc, vecs[i].e_en, vecs[i].e_go};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", i, got, exp);
            end
        end

        cyc(0, 0, 1, 0, 0);
        chk("ship2_lives", int'(lives), 1);
        wait_pause_out(cnt);
        chk("ship2_pause_len", cnt, 8);
        chk("ship2_resume", int'({state, clear, ScoreClear}), int'({3'd4, 1'b1, 1'b0}));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("ship3_over", int'({state, lives, gameOver}), int'({3'd5, 2'd0, 1'b1}));
        cyc(0, 1, 1, 1, 1);
        chk("over_ignores", int'({state, lives}), int'({3'd5, 2'd0}));

        cyc(1, 0, 0, 0, 0);
        chk("restart_init", int'({state, lives}), int'({3'd1, 2'd3}));
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        chk("landed_ship_over", int'({state, lives, gameOver}), int'({3'd5, 2'd0, 1'b1}));

        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk($sformatf("alldead_%0d", i), int'({state, level}), int'({3'd3, 3'((i > 7) ? 7 : i)}));
            wait_play($sformatf("alldead_back_%0d", i));
        end
        chk("level_sat", int'(level), 7);

        cyc(0, 0, 1, 0, 0);
        chk("hits_prep_lives", int'(lives), 2);
        wait_play("hits_prep_play");
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
        chk("hits15_lives", int'(lives), 2);
        cyc(0, 1, 0, 0, 0);
        chk("hits16_bonus", int'(lives), 3);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0);
        chk("hits32_sat", int'({state, lives}), int'({3'd2, 2'd3}));
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("hit_ship_same", int'({state, lives}), int'({3'd3, 2'd2}));

        cyc(0, 0, 0, 0, 0);
        #2;
        reset = 0;
        #1;
        chk("async_reset", int'({state, lives, level, clear, ScoreClear, Enable, gameOver}), 0);
        @(posedge clk);
        #1;
        reset = 1;
        cyc(0, 0, 0, 0, 0);
        chk("post_reset_idle", int'(state), 0);
        cyc(1, 0, 0, 0, 0);
        chk("post_reset_init", int'({state, lives, level, clear, ScoreClear}),
            int'({3'd1, 2'd3, 3'd0, 1'b1, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
